// File: rtl/reg_wb_arbiter.sv
// Two-requester round-robin writeback arbiter feeding a registered register-file
// write port, with drop/out-of-range filtering and an in-flight hazard query.
module reg_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [5:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [5:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        hold,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic [5:0]  q_addr,
  output logic        q_hazard,
  output logic [7:0]  drop_cnt,
  output logic        err_oor
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // Requesters keep valid/addr/data stable until accepted; ready is a pure
  // function of the current valids, hold and the last-grant pointer.

  logic        r_live;     // 0 during reset and for the reset-release edge
  logic        r_last_b;   // 1: B was granted most recently
  logic        r_wr_en;
  logic [5:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [7:0]  r_drop_cnt;
  logic        r_err_oor;

  logic        w_open;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_acc;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic        w_drop;

  always_comb begin
    w_open    = r_live && !hold;
    w_grant_a = w_open && a_valid && (!b_valid || r_last_b);
    w_grant_b = w_open && b_valid && (!a_valid || !r_last_b);
    w_acc     = w_grant_a || w_grant_b;
    w_addr    = w_grant_b ? b_addr : a_addr;
    w_data    = w_grant_b ? b_data : a_data;
    // Register 0 is hardwired and addr[5] is outside the 32-entry file.
    w_drop    = (w_addr == 6'd0) || w_addr[5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_last_b   <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 6'd0;
      r_wr_data  <= 32'd0;
      r_drop_cnt <= 8'd0;
      r_err_oor  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_wr_en <= w_acc && !w_drop;
      if (w_acc) begin
        r_last_b <= w_grant_b;
      end
      if (w_acc && !w_drop) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
      if (w_acc && w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_acc && w_addr[5]) begin
        r_err_oor <= 1'b1;
      end
    end
  end

  assign a_ready  = w_grant_a;
  assign b_ready  = w_grant_b;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign drop_cnt = r_drop_cnt;
  assign err_oor  = r_err_oor;
  assign q_hazard = r_wr_en && (r_wr_addr == q_addr) && (q_addr != 6'd0);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: scenario tasks plus a write-port
// scoreboard fed with expected {addr,data} whenever a real write is driven.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, hold;
  logic [5:0]  a_addr, b_addr, q_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, wr_en, q_hazard, err_oor;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [37:0] exp_q[$];

  reg_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_addr(q_addr), .q_hazard(q_hazard), .drop_cnt(drop_cnt), .err_oor(err_oor)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every strobed write must match the oldest expected write
  always @(posedge clk) begin
    logic [37:0] exp_w;
    #1;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got=%0d/%h exp=none", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          failures++;
          $display("FAIL sb_write got=%0d/%h exp=%0d/%h", wr_addr, wr_data, exp_w[37:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; hold = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0; q_addr = 0;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    a_valid = 1; a_addr = 6'd3; a_data = 32'hAA;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b%b exp=00", a_ready, b_ready); end
    checks++; if ({wr_en, wr_addr, wr_data, drop_cnt, err_oor} !== 48'd0) begin failures++; $display("FAIL rst_outputs got=%b/%0d/%h/%0d/%b exp=0", wr_en, wr_addr, wr_data, drop_cnt, err_oor); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_release_ready got=%b exp=0", a_ready); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_release_edge_wr_en got=%b exp=0", wr_en); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_live_ready got=%b exp=1", a_ready); end
    @(negedge clk); a_valid = 0;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    a_valid = 1; a_addr = 6'd5; a_data = 32'h11;
    b_valid = 1; b_addr = 6'd6; b_data = 32'h22;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL rr_first got=%b%b exp=10", a_ready, b_ready); end
    exp_q.push_back({6'd5, 32'h11});
    @(posedge clk); #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd5, 32'h11}) begin failures++; $display("FAIL rr_write_a got=%b/%0d/%h exp=1/5/11", wr_en, wr_addr, wr_data); end
    @(negedge clk); a_valid = 0; #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin failures++; $display("FAIL rr_second got=%b%b exp=01", a_ready, b_ready); end
    exp_q.push_back({6'd6, 32'h22});
    @(posedge clk); #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd6, 32'h22}) begin failures++; $display("FAIL rr_write_b got=%b/%0d/%h exp=1/6/22", wr_en, wr_addr, wr_data); end
    @(negedge clk); b_valid = 0;
    @(posedge clk); #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 6'd6, 32'h22}) begin failures++; $display("FAIL rr_idle_hold got=%b/%0d/%h exp=0/6/22", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = $urandom;
      a_valid = 1; a_addr = 6'(10 + i); a_data = d;
      #1;
      checks++; if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL b2b_ready[%0d] got=%b%b exp=10", i, a_ready, b_ready); end
      exp_q.push_back({6'(10 + i), d});
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b1 || wr_addr !== 6'(10 + i)) begin failures++; $display("FAIL b2b_write[%0d] got=%b/%0d exp=1/%0d", i, wr_en, wr_addr, 10 + i); end
    end
    @(negedge clk); a_valid = 0;
  endtask

  task automatic test_drop();
    @(negedge clk);
    b_valid = 1; b_addr = 6'd0; b_data = 32'h33; #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL drop0_ready got=%b exp=1", b_ready); end
    @(posedge clk); #1;
    checks++; if ({wr_en, drop_cnt, err_oor} !== {1'b0, 8'd1, 1'b0}) begin failures++; $display("FAIL drop0 got=%b/%0d/%b exp=0/1/0", wr_en, drop_cnt, err_oor); end
    @(negedge clk);
    b_addr = 6'h21; b_data = 32'h44; #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL drop_oor_ready got=%b exp=1", b_ready); end
    @(posedge clk); #1;
    checks++; if ({wr_en, drop_cnt, err_oor} !== {1'b0, 8'd2, 1'b1}) begin failures++; $display("FAIL drop_oor got=%b/%0d/%b exp=0/2/1", wr_en, drop_cnt, err_oor); end
    @(negedge clk); b_valid = 0;
  endtask

  task automatic test_hold();
    // last grant is B here, so A must win once hold releases
    @(negedge clk);
    hold = 1;
    a_valid = 1; a_addr = 6'd12; a_data = 32'h55;
    b_valid = 1; b_addr = 6'd13; b_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({a_ready, b_ready} !== 2'b00) begin failures++; $display("FAIL hold_ready[%0d] got=%b%b exp=00", i, a_ready, b_ready); end
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL hold_wr_en[%0d] got=%b exp=0", i, wr_en); end
      @(negedge clk);
    end
    hold = 0; #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL hold_release got=%b%b exp=10", a_ready, b_ready); end
    exp_q.push_back({6'd12, 32'h55});
    @(posedge clk);
    @(negedge clk);
    a_addr = 6'd14; a_data = 32'h77; #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin failures++; $display("FAIL hold_rr_next got=%b%b exp=01", a_ready, b_ready); end
    exp_q.push_back({6'd13, 32'h66});
    @(posedge clk);
    @(negedge clk); b_valid = 0; #1;
    exp_q.push_back({6'd14, 32'h77});
    @(posedge clk);
    @(negedge clk); a_valid = 0;
  endtask

  task automatic test_hazard();
    a_valid = 1; a_addr = 6'd9; a_data = 32'h99;
    exp_q.push_back({6'd9, 32'h99});
    @(posedge clk); #1;
    a_valid = 0;
    q_addr = 6'd9; #1;
    checks++; if (q_hazard !== 1'b1) begin failures++; $display("FAIL hazard_hit got=%b exp=1", q_hazard); end
    q_addr = 6'd0; #1;
    checks++; if (q_hazard !== 1'b0) begin failures++; $display("FAIL hazard_zero got=%b exp=0", q_hazard); end
    q_addr = 6'd8; #1;
    checks++; if (q_hazard !== 1'b0) begin failures++; $display("FAIL hazard_other got=%b exp=0", q_hazard); end
    q_addr = 6'd9;
    @(posedge clk); #2;
    checks++; if (q_hazard !== 1'b0) begin failures++; $display("FAIL hazard_idle got=%b exp=0", q_hazard); end
    @(negedge clk);
  endtask

  task automatic test_reset_midcycle();
    a_valid = 1; a_addr = 6'd7; a_data = 32'hCAFE;
    exp_q.push_back({6'd7, 32'hCAFE});
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", wr_en); end
    a_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({wr_en, wr_addr, wr_data, drop_cnt, err_oor} !== 48'd0) begin failures++; $display("FAIL mid_reset got=%b/%0d/%h/%0d/%b exp=0", wr_en, wr_addr, wr_data, drop_cnt, err_oor); end
    release_reset();
    // pointer back to B: A wins the first contest
    a_valid = 1; b_valid = 1; a_addr = 6'd1; b_addr = 6'd2; a_data = 32'h1; b_data = 32'h2; #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL mid_rr_reset got=%b%b exp=10", a_ready, b_ready); end
    exp_q.push_back({6'd1, 32'h1});
    @(posedge clk); @(negedge clk);
    a_valid = 0; #1;
    exp_q.push_back({6'd2, 32'h2});
    @(posedge clk); @(negedge clk);
    b_valid = 0;
  endtask

  task automatic test_saturate();
    a_valid = 1; a_addr = 6'd0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 100 || i == 254 || i == 255 || i == 300) begin
        logic [7:0] exp_cnt;
        exp_cnt = (i > 255) ? 8'd255 : 8'(i);
        checks++; if (drop_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, drop_cnt, exp_cnt); end
      end
    end
    @(negedge clk); a_valid = 0;
    checks++; if (err_oor !== 1'b0) begin failures++; $display("FAIL sat_err got=%b exp=0", err_oor); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_drop();
    test_hold();
    test_hazard();
    test_reset_midcycle();
    test_saturate();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width, meaning.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 a_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-005 a_addr  in  6  requester A destination register.
REQ-006 a_data  in  32  requester A write data.
REQ-007 a_ready  out  1  requester A write accepted this cycle (combinational).
REQ-008 b_valid, b_addr, b_data, b_ready  same widths and meaning as A, for requester B (load writeback).
REQ-009 hold  in  1  pipeline stall; while 1, no write is accepted.
REQ-010 wr_en  out  1  registered write strobe to the register-file write port.
REQ-011 wr_addr  out  6  registered write address.
REQ-012 wr_data  out  32  registered write data.
REQ-013 q_addr  in  6  hazard query address.
REQ-014 q_hazard  out  1  a registered write to q_addr is in flight (combinational).
REQ-015 drop_cnt  out  8  saturating count of dropped writes.
REQ-016 err_oor  out  1  sticky flag: an accepted write had addr[5]=1.

Function
REQ-017 Handshake: a transfer occurs on a rising edge where valid and ready are both 1; a requester SHALL hold valid, addr and data stable until accepted.
REQ-018 hold=1 SHALL force a_ready=b_ready=0.
REQ-019 hold=0, one requester valid: that requester's ready SHALL be 1, the other 0.
REQ-020 hold=0, both valid: ready SHALL go to the requester not granted most recently (round-robin); the loser's ready SHALL be 0.
REQ-021 The last-grant pointer SHALL update on every accepted transfer to the accepted requester.
REQ-022 Ready SHALL never be 1 while the matching valid is 0, and at most one ready SHALL be 1 in any cycle.
REQ-023 Latency: a transfer accepted at edge k SHALL drive wr_en=1 with the accepted addr and data from edge k to edge k+1, so the register file captures it on the intervening falling edge.
REQ-024 With no transfer at edge k, wr_en SHALL be 0 after edge k; wr_addr and wr_data SHALL hold their previous values.
REQ-025 Drop rule: an accepted transfer with addr=0 or addr[5]=1 SHALL complete the handshake but SHALL leave wr_en=0 after that edge.
REQ-026 Each dropped transfer SHALL increment drop_cnt by 1; at 255 the count SHALL saturate.
REQ-027 An accepted transfer with addr[5]=1 SHALL set err_oor; only reset SHALL clear it.
REQ-028 The output stage SHALL never back-pressure: a new transfer may be accepted on every edge, including back-to-back edges from the same requester.
REQ-029 q_hazard SHALL be 1 when wr_en=1, wr_addr=q_addr and q_addr is nonzero; otherwise it SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0, err_oor=0, and set the last-grant pointer to B, so that A wins the first contest.
REQ-031 While rst_n=0, a_ready and b_ready SHALL be 0.
REQ-032 If reset asserts while wr_en=1, the in-flight write SHALL be cancelled (wr_en=0 at once), and no transfer SHALL be accepted on the reset-release edge.

Verification
REQ-033 After reset, A(addr=5,data=0x11) and B(addr=6,data=0x22) valid together -> A accepted first, wr_en with 5/0x11; next edge B accepted, wr_en with 6/0x22.
REQ-034 A held valid for 4 edges with B idle -> 4 back-to-back writes from A, wr_en continuously 1, b_ready=0 throughout.
REQ-035 B write with addr=0, then B write with addr=0x21 -> both handshakes complete, wr_en stays 0, drop_cnt=2, err_oor=1.
REQ-036 hold=1 with both requesters valid for 3 cycles -> no ready, wr_en=0; on release, the round-robin winner is the requester not granted most recently.
REQ-037 wr_en=1 with wr_addr=9: q_addr=9 -> q_hazard=1; q_addr=0 or q_addr=8 -> q_hazard=0.
REQ-038 Assert rst_n=0 mid-cycle while wr_en=1 -> wr_en drops before the next clock edge; 300 drops -> drop_cnt=255.
